// File: rtl/fwd_pkg.sv
// Shared constants, FSM state encoding and helpers for the forwarding/hazard unit.
package fwd_pkg;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    // Wide enough for the largest supported bubble length (LOAD_LAT up to 7)
    localparam int LAT_CNT_W = 3;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/fwd_src_cmp.sv
// One source operand: forwarding priority select plus its load-use compare
// against the instruction sitting in ID/EX.
module fwd_src_cmp
    import fwd_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int ZERO_REG_EN = 1
) (
    input  logic [ADDR_W-1:0] idex_src,
    input  logic [ADDR_W-1:0] ifid_src,
    input  logic [ADDR_W-1:0] idex_dst,
    input  logic              idex_mem_read,
    input  logic [ADDR_W-1:0] exmem_dst,
    input  logic              exmem_reg_write,
    input  logic [ADDR_W-1:0] memwb_dst,
    input  logic              memwb_reg_write,
    output logic [1:0]        sel,
    output logic              load_use
);

    logic idex_live;
    logic ifid_live;

    // Register 0 is hard-wired, so it never carries a dependency when enabled
    assign idex_live = !((ZERO_REG_EN != 0) && (idex_src == '0));
    assign ifid_live = !((ZERO_REG_EN != 0) && (ifid_src == '0));

    always_comb begin
        sel = FWD_REG;
        if (idex_live && exmem_reg_write && (exmem_dst == idex_src)) begin
            sel = FWD_EXMEM;
        end else if (idex_live && memwb_reg_write && (memwb_dst == idex_src)) begin
            sel = FWD_MEMWB;
        end
    end

    assign load_use = idex_mem_read && ifid_live && (ifid_src == idex_dst);

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Pipeline operand forwarding selects, load-use stall/bubble sequencing and
// saturating event counters.
module forwarding_hazard_unit
    import fwd_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int NUM_SRC     = 2,
    parameter int LOAD_LAT    = 1,
    parameter int ZERO_REG_EN = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC*ADDR_W-1:0] idex_src,
    input  logic [NUM_SRC*ADDR_W-1:0] ifid_src,
    input  logic [ADDR_W-1:0]         idex_dst,
    input  logic                      idex_mem_read,
    input  logic [ADDR_W-1:0]         exmem_dst,
    input  logic                      exmem_reg_write,
    input  logic [ADDR_W-1:0]         memwb_dst,
    input  logic                      memwb_reg_write,
    input  logic                      flush,
    output logic [2*NUM_SRC-1:0]      fwd_sel,
    output logic                      stall,
    output logic                      bubble,
    output logic [15:0]               fwd_cnt,
    output logic [15:0]               stall_cnt
);

    localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(LOAD_LAT - 1);

    state_t               state_reg;
    logic [LAT_CNT_W-1:0] lat_cnt_reg;
    logic [LAT_CNT_W-1:0] lat_cnt_next;
    logic [15:0]          fwd_cnt_reg;
    logic [15:0]          stall_cnt_reg;

    logic [2*NUM_SRC-1:0] fwd_sel_raw;
    logic [NUM_SRC-1:0]   load_use_vec;
    logic                 hazard;
    logic                 hold_active;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        fwd_src_cmp #(
            .ADDR_W      (ADDR_W),
            .ZERO_REG_EN (ZERO_REG_EN)
        ) u_cmp (
            .idex_src        (idex_src[gi*ADDR_W +: ADDR_W]),
            .ifid_src        (ifid_src[gi*ADDR_W +: ADDR_W]),
            .idex_dst        (idex_dst),
            .idex_mem_read   (idex_mem_read),
            .exmem_dst       (exmem_dst),
            .exmem_reg_write (exmem_reg_write),
            .memwb_dst       (memwb_dst),
            .memwb_reg_write (memwb_reg_write),
            .sel             (fwd_sel_raw[gi*2 +: 2]),
            .load_use        (load_use_vec[gi])
        );
    end

    assign hazard = |load_use_vec;

    // New hazards are only looked at in RUN; a stall in progress runs to completion
    assign hold_active = (state_reg == STALL) || hazard;

    assign fwd_sel = rst_n ? fwd_sel_raw : '0;
    assign stall   = rst_n && hold_active && !flush;
    assign bubble  = rst_n && hold_active;

    assign lat_cnt_next = lat_cnt_reg - LAT_CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= RUN;
            lat_cnt_reg   <= '0;
            fwd_cnt_reg   <= '0;
            stall_cnt_reg <= '0;
        end else begin
            if (flush) begin
                state_reg   <= RUN;
                lat_cnt_reg <= '0;
            end else if (state_reg == RUN) begin
                // The hazard cycle itself is the first bubble; STALL covers the rest
                if (hazard && (LAT_INIT != '0)) begin
                    state_reg   <= STALL;
                    lat_cnt_reg <= LAT_INIT;
                end
            end else begin
                if (lat_cnt_reg == '0 || lat_cnt_next == '0) begin
                    state_reg   <= RUN;
                    lat_cnt_reg <= '0;
                end else begin
                    lat_cnt_reg <= lat_cnt_next;
                end
            end

            if (stall) begin
                stall_cnt_reg <= sat_inc16(stall_cnt_reg);
            end
            if ((|fwd_sel) && !stall) begin
                fwd_cnt_reg <= sat_inc16(fwd_cnt_reg);
            end
        end
    end

    assign fwd_cnt   = fwd_cnt_reg;
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed scoreboard bench for forwarding_hazard_unit (LOAD_LAT=3).
module tb_forwarding_hazard_unit;

    localparam int ADDR_W  = 4;
    localparam int NUM_SRC = 2;

    localparam int K_FWD   = 0;
    localparam int K_STALL = 1;
    localparam int K_BUB   = 2;
    localparam int K_FCNT  = 3;
    localparam int K_SCNT  = 4;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_SRC*ADDR_W-1:0] idex_src;
    logic [NUM_SRC*ADDR_W-1:0] ifid_src;
    logic [ADDR_W-1:0]         idex_dst;
    logic                      idex_mem_read;
    logic [ADDR_W-1:0]         exmem_dst;
    logic                      exmem_reg_write;
    logic [ADDR_W-1:0]         memwb_dst;
    logic                      memwb_reg_write;
    logic                      flush;
    logic [2*NUM_SRC-1:0]      fwd_sel;
    logic                      stall;
    logic                      bubble;
    logic [15:0]               fwd_cnt;
    logic [15:0]               stall_cnt;

    forwarding_hazard_unit #(
        .ADDR_W      (ADDR_W),
        .NUM_SRC     (NUM_SRC),
        .LOAD_LAT    (3),
        .ZERO_REG_EN (1)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .idex_src        (idex_src),
        .ifid_src        (ifid_src),
        .idex_dst        (idex_dst),
        .idex_mem_read   (idex_mem_read),
        .exmem_dst       (exmem_dst),
        .exmem_reg_write (exmem_reg_write),
        .memwb_dst       (memwb_dst),
        .memwb_reg_write (memwb_reg_write),
        .flush           (flush),
        .fwd_sel         (fwd_sel),
        .stall           (stall),
        .bubble          (bubble),
        .fwd_cnt         (fwd_cnt),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic push(input string tag, input int kind, input logic [31:0] e);
        exp_t x;
        x.tag  = tag;
        x.kind = kind;
        x.exp  = e;
        sb.push_back(x);
    endtask

    // Expect stall/bubble outputs in one call
    task automatic push_sb(input string tag, input logic s, input logic b);
        push({tag, "_stall"}, K_STALL, {31'd0, s});
        push({tag, "_bubble"}, K_BUB, {31'd0, b});
    endtask

    task automatic drain(input string step);
        exp_t        x;
        logic [31:0] obs;
        $display("step %s: fwd_sel=%b stall=%b bubble=%b fwd_cnt=%0d stall_cnt=%0d",
                 step, fwd_sel, stall, bubble, fwd_cnt, stall_cnt);
        while (sb.size() > 0) begin
            x = sb.pop_front();
            case (x.kind)
                K_FWD:   obs = {28'd0, fwd_sel};
                K_STALL: obs = {31'd0, stall};
                K_BUB:   obs = {31'd0, bubble};
                K_FCNT:  obs = {16'd0, fwd_cnt};
                default: obs = {16'd0, stall_cnt};
            endcase
            checks++;
            assert (obs === x.exp) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", x.tag, obs, x.exp);
            end
        end
    endtask

    task automatic idle();
        idex_src        = '0;
        ifid_src        = '0;
        idex_dst        = '0;
        idex_mem_read   = 1'b0;
        exmem_dst       = '0;
        exmem_reg_write = 1'b0;
        memwb_dst       = '0;
        memwb_reg_write = 1'b0;
        flush           = 1'b0;
    endtask

    task automatic load_hazard();
        idex_mem_read = 1'b1;
        idex_dst      = 4'd7;
        ifid_src      = {4'd7, 4'd1};
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        // Reset: everything quiet even with a forwarding match and a load-use present
        idex_src = {4'd10, 4'd5}; exmem_dst = 4'd5; exmem_reg_write = 1'b1;
        load_hazard();
        push("rst_fwd", K_FWD, 32'h0);
        push_sb("rst", 1'b0, 1'b0);
        push("rst_fcnt", K_FCNT, 32'd0);
        push("rst_scnt", K_SCNT, 32'd0);
        #1 drain("reset");

        @(negedge clk); idle(); rst_n = 1'b1;
        push("idle_fwd", K_FWD, 32'h0);
        push_sb("idle", 1'b0, 1'b0);
        #1 drain("idle");

        @(negedge clk); idle();
        idex_src = {4'd10, 4'd5}; exmem_dst = 4'd5; exmem_reg_write = 1'b1;
        push("exmem_fwd", K_FWD, 32'b0010);
        push("exmem_stall", K_STALL, 32'd0);
        push("exmem_fcnt", K_FCNT, 32'd0);
        #1 drain("exmem");

        @(negedge clk); idle();
        idex_src = {4'd10, 4'd3};
        exmem_dst = 4'd10; exmem_reg_write = 1'b1;
        memwb_dst = 4'd10; memwb_reg_write = 1'b1;
        push("prio_fwd", K_FWD, 32'b1000);
        push("prio_fcnt", K_FCNT, 32'd1);
        #1 drain("priority");

        @(negedge clk); idle();
        idex_src = {4'd2, 4'd10};
        exmem_dst = 4'd10; memwb_dst = 4'd10; memwb_reg_write = 1'b1;
        push("memwb_fwd", K_FWD, 32'b0001);
        push("memwb_fcnt", K_FCNT, 32'd2);
        #1 drain("memwb");

        @(negedge clk); idle();
        idex_src = {4'd6, 4'd6};
        exmem_dst = 4'd6; memwb_dst = 4'd6; memwb_reg_write = 1'b1;
        push("nowr_fwd", K_FWD, 32'b0101);
        push("nowr_fcnt", K_FCNT, 32'd3);
        #1 drain("exmem_no_write");

        @(negedge clk); idle();
        exmem_reg_write = 1'b1; memwb_reg_write = 1'b1;
        push("zero_fwd", K_FWD, 32'b0000);
        push("zero_fcnt", K_FCNT, 32'd4);
        #1 drain("zero_reg_fwd");

        @(negedge clk); idle();
        idex_mem_read = 1'b1;
        push_sb("zero_lu", 1'b0, 1'b0);
        push("zero_lu_scnt", K_SCNT, 32'd0);
        #1 drain("zero_reg_load");

        // Load-use, LOAD_LAT=3; forwarding during stall must not count
        @(negedge clk); idle(); load_hazard();
        idex_src = {4'd0, 4'd5}; exmem_dst = 4'd5; exmem_reg_write = 1'b1;
        push_sb("lu1", 1'b1, 1'b1);
        push("lu1_fwd", K_FWD, 32'b0010);
        push("lu1_fcnt", K_FCNT, 32'd4);
        #1 drain("load_use_c1");

        @(negedge clk);
        push_sb("lu2", 1'b1, 1'b1);
        push("lu2_scnt", K_SCNT, 32'd1);
        #1 drain("load_use_c2");

        @(negedge clk); idle();
        push_sb("lu3", 1'b1, 1'b1);
        push("lu3_scnt", K_SCNT, 32'd2);
        #1 drain("load_use_c3");

        @(negedge clk); idle();
        push_sb("lu4", 1'b0, 1'b0);
        push("lu4_scnt", K_SCNT, 32'd3);
        push("lu4_fcnt", K_FCNT, 32'd4);
        #1 drain("load_use_done");

        // Flush on the second stall cycle
        @(negedge clk); idle(); load_hazard();
        push_sb("fl1", 1'b1, 1'b1);
        #1 drain("flush_c1");

        @(negedge clk); idle(); flush = 1'b1;
        push_sb("fl2", 1'b0, 1'b1);
        push("fl2_scnt", K_SCNT, 32'd4);
        #1 drain("flush_c2");

        @(negedge clk); idle();
        push_sb("fl3", 1'b0, 1'b0);
        push("fl3_scnt", K_SCNT, 32'd4);
        #1 drain("flush_after");

        // Flush coinciding with the hazard cycle
        @(negedge clk); idle(); load_hazard(); flush = 1'b1;
        push_sb("flh", 1'b0, 1'b1);
        #1 drain("flush_hazard");

        @(negedge clk); idle();
        push_sb("flh_next", 1'b0, 1'b0);
        push("flh_scnt", K_SCNT, 32'd4);
        #1 drain("flush_hazard_after");

        // Reset in the middle of a stall
        @(negedge clk); idle(); load_hazard();
        push_sb("rs1", 1'b1, 1'b1);
        #1 drain("rst_stall_c1");

        @(negedge clk); idle(); rst_n = 1'b0;
        push_sb("rs2", 1'b0, 1'b0);
        #1 drain("rst_stall_asserted");

        @(negedge clk); idle(); rst_n = 1'b1;
        push_sb("rs3", 1'b0, 1'b0);
        push("rs3_fcnt", K_FCNT, 32'd0);
        push("rs3_scnt", K_SCNT, 32'd0);
        #1 drain("rst_stall_released");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
